seq_sub_16bit: RTL and testbench

SEQ_SUB_16BIT -- requirements
Module: seq_sub_16bit

---
 rtl/seq_sub_16bit_pkg.sv | 13 +
 rtl/seq_sub_16bit_sub_slice.sv | 15 +
 rtl/seq_sub_16bit.sv | 107 ++++++++++
 tb/tb_seq_sub_16bit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/seq_sub_16bit_pkg.sv
// Shared defaults and FSM state encoding for the sequential slice subtractor.
package seq_sub_16bit_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLICE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_sub_16bit_sub_slice.sv
// Combinational SLICE-bit borrow subtractor: {bout, d} = a - b - bin.
module sub_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             bin,
    output logic [SLICE-1:0] d,
    output logic             bout
);

    // One extra bit catches the borrow as the sign of the widened result.
    assign {bout, d} = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bin};

endmodule

// File: rtl/seq_sub_16bit.sv
// Sequential subtractor: one SLICE-bit slice per cycle through a single
// shared sub_slice, LSB first; flags published together on completion.
module seq_sub_16bit
    import seq_sub_16bit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE   // WIDTH must be a multiple of SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int MSB    = WIDTH - 1;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q, acc_q, acc_nxt;
    logic             bq;
    logic [CW-1:0]    cnt;
    logic             last;

    logic [SLICE-1:0] sa, sb, sd;
    logic             sbout;

    assign last = (cnt == CW'(NSLICE - 1));

    always_comb begin
        sa = a_q[cnt*SLICE +: SLICE];
        sb = b_q[cnt*SLICE +: SLICE];
        acc_nxt = acc_q;
        acc_nxt[cnt*SLICE +: SLICE] = sd;
    end

    sub_slice #(.SLICE(SLICE)) u_slice (
        .a    (sa),
        .b    (sb),
        .bin  (bq),
        .d    (sd),
        .bout (sbout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            bq     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        bq    <= borrow_in;
                        acc_q <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_nxt;
                    bq    <= sbout;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        // Outputs only move here, so partial sums never show.
                        diff   <= acc_nxt;
                        borrow <= sbout;
                        ovf    <= (a_q[MSB] != b_q[MSB]) && (acc_nxt[MSB] != a_q[MSB]);
                        zero   <= (acc_nxt == '0);
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_sub_16bit.sv
// Randomized self-checking bench for seq_sub_16bit against an integer model.
module tb_seq_sub_16bit;

    logic        clk = 1'b0;
    logic        rst, start, borrow_in;
    logic [15:0] a, b;
    logic        busy, done, borrow, ovf, zero;
    logic [15:0] diff;

    int n_chk  = 0;
    int n_fail = 0;

    seq_sub_16bit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .borrow_in (borrow_in),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .borrow    (borrow),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned and signed views of a - b - bin.
    task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin,
                         output logic [15:0] md, output logic mbr, output logic mov,
                         output logic mz);
        int r, sr;
        r   = int'(ma) - int'(mb) - int'(mbin);
        sr  = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        mbr = (r < 0);
        md  = 16'(r + 65536);
        mov = (sr > 32767) || (sr < -32768);
        mz  = (md == 16'h0);
    endtask

    task automatic chk_res(input string tag, input logic [15:0] ma, input logic [15:0] mb,
                           input logic mbin);
        logic [15:0] ed;
        logic        eb, eo, ez;
        model(ma, mb, mbin, ed, eb, eo, ez);
        chk({tag, "_diff"}, 32'(diff), 32'(ed));
        chk({tag, "_borrow"}, 32'(borrow), 32'(eb));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
        chk({tag, "_zero"}, 32'(zero), 32'(ez));
    endtask

    // One operation; optionally pokes start with junk operands mid-run.
    task automatic run_op(input logic [15:0] oa, input logic [15:0] ob, input logic obin,
                          input bit junk);
        int cyc;
        logic [15:0] hold;
        @(negedge clk);
        a = oa; b = ob; borrow_in = obin; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); borrow_in = 1'($urandom);
        cyc = 0;
        forever begin
            @(negedge clk);
            if (busy && done) chk("busy_done_excl", 32'(1), 32'(0));
            if (done) break;
            if (busy) cyc++;
            if (junk && cyc == 2) begin
                start = 1'b1; a = 16'($urandom); b = 16'($urandom);
            end
            if (cyc == 3) start = 1'b0;
            if (cyc > 20) begin
                start = 1'b0;
                chk("done_timeout", 32'(0), 32'(1));
                return;
            end
        end
        chk("latency", 32'(cyc), 32'(4));
        chk("busy_at_done", 32'(busy), 32'(0));
        chk_res("op", oa, ob, obin);
        hold = diff;
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'(0));
        chk("diff_hold", 32'(diff), 32'(hold));
    endtask

    logic [15:0] ops_a [0:9];
    logic [15:0] ops_b [0:9];
    logic        ops_c [0:9];

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_diff", 32'(diff), 32'(0));
        chk("rst_flags", 32'({borrow, ovf, zero}), 32'(0));

        // Reset wins over start in the same cycle.
        start = 1'b1; a = 16'h1111; b = 16'h0001;
        @(negedge clk);
        chk("rst_prio_busy", 32'(busy), 32'(0));
        start = 1'b0; rst = 1'b0;

        run_op(16'h1234, 16'h0234, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0005, 16'h0005, 1'b1, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1);
        run_op(16'hBEEF, 16'hBEEF, 1'b0, 1'b1);
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

        // Back-to-back: start held for 10 edges, new operands every cycle.
        for (int i = 0; i < 10; i++) begin
            ops_a[i] = 16'($urandom); ops_b[i] = 16'($urandom); ops_c[i] = 1'($urandom);
        end
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            if (i >= 1) begin
                chk("b2b_done", 32'(done), 32'((i == 5) || (i == 10)));
                chk("b2b_busy", 32'(busy), 32'((i != 5) && (i != 10) && (i <= 10)));
            end
            if (i == 5)  chk_res("b2b0", ops_a[0], ops_b[0], ops_c[0]);
            if (i == 10) chk_res("b2b5", ops_a[5], ops_b[5], ops_c[5]);
            if (i < 10) begin
                a = ops_a[i]; b = ops_b[i]; borrow_in = ops_c[i]; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end

        // Abort in the second RUN cycle.
        @(negedge clk);
        a = 16'h4321; b = 16'h1234; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_diff", 32'(diff), 32'(0));
        chk("abort_flags", 32'({borrow, ovf, zero}), 32'(0));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done | busy), 32'(0));
        end
        run_op(16'h4321, 16'h1234, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
